// File: rtl/result_stream_tx_if.sv
// Handshake bundle between the scalar-multiplication core, the result serializer and the output port.
// The serializer side uses the master modport; the core and the sink side use the slave modport.
interface result_stream_tx_if #(
    parameter int DATA_W = 64,
    parameter int RES_W  = 512
);
    logic              i_res_valid;
    logic              o_res_ready;
    logic [RES_W-1:0]  i_res_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_out_data;
    logic              o_last;
    logic              o_frame_done;

    modport master (
        input  i_res_valid, i_res_data, i_out_ready,
        output o_res_ready, o_out_valid, o_out_data, o_last, o_frame_done
    );

    modport slave (
        output i_res_valid, i_res_data, i_out_ready,
        input  o_res_ready, o_out_valid, o_out_data, o_last, o_frame_done
    );
endinterface

// File: rtl/result_stream_tx.sv
// Serializes one RES_W-bit {X,Y} result into NUM_WORDS DATA_W-bit words, most significant word first,
// under valid/ready backpressure. A new result may be captured during the last word's handshake.
module result_stream_tx #(
    parameter int DATA_W = 64,
    parameter int RES_W  = 512
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    result_stream_tx_if.master   bus
);
    localparam int NUM_WORDS = RES_W / DATA_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [RES_W-1:0]  res_q;
    logic              done_q;
    logic              last_word;
    logic              res_ready;
    logic [DATA_W-1:0] word;

    assign last_word = (state_q == SEND) && (cnt_q == LAST_CNT);
    // Ready is combinational on i_out_ready so a new result can slip in behind the last word.
    assign res_ready = (state_q == IDLE) || (last_word && bus.i_out_ready);

    always_comb begin
        word = '0;
        if (state_q == SEND) begin
            word = res_q[RES_W-1-DATA_W*int'(cnt_q) -: DATA_W];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_res_valid) begin
                        res_q   <= bus.i_res_data;
                        cnt_q   <= '0;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bus.i_out_ready) begin
                        if (cnt_q == LAST_CNT) begin
                            done_q <= 1'b1;
                            cnt_q  <= '0;
                            if (bus.i_res_valid) begin
                                res_q <= bus.i_res_data;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_res_ready  = res_ready;
    assign bus.o_out_valid  = (state_q == SEND);
    assign bus.o_out_data   = word;
    assign bus.o_last       = last_word;
    assign bus.o_frame_done = done_q;
endmodule

// File: tb/tb_result_stream_tx.sv
// Randomized scoreboard bench for result_stream_tx: accepted results are split into expected words
// by a queue model; a negedge monitor compares every cycle's outputs against the queue front.
module tb_result_stream_tx;
    localparam int DATA_W = 64;
    localparam int RES_W  = 512;
    localparam int NW     = RES_W / DATA_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    result_stream_tx_if #(.DATA_W(DATA_W), .RES_W(RES_W)) bus ();

    result_stream_tx #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];
    bit done_exp  = 1'b0;
    int acc_cnt   = 0;
    int ready_mode = 0;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want completion", name);
    endtask

    function automatic logic [RES_W-1:0] rnd512();
        logic [RES_W-1:0] v;
        v = '0;
        for (int k = 0; k < RES_W / 32; k++) v = {v[RES_W-33:0], 32'($urandom())};
        return v;
    endfunction

    // Monitor / reference model: the in-flight frame is just a queue of remaining words.
    always @(negedge clk) begin : monitor
        bit mv, ml, mready, hs;
        logic [DATA_W-1:0] md;
        logic [RES_W-1:0]  tmp;
        logic [DATA_W-1:0] words[NW];
        if (!rst_n) begin
            exp_q.delete();
            done_exp = 1'b0;
            chk("rst_valid", 64'(bus.o_out_valid), 64'd0);
            chk("rst_data", bus.o_out_data, 64'd0);
            chk("rst_ready", 64'(bus.o_res_ready), 64'd1);
            chk("rst_last", 64'(bus.o_last), 64'd0);
            chk("rst_done", 64'(bus.o_frame_done), 64'd0);
        end else begin
            mv     = exp_q.size() > 0;
            ml     = exp_q.size() == 1;
            md     = mv ? exp_q[0] : '0;
            mready = (exp_q.size() == 0) || (ml && bus.i_out_ready);
            chk("valid", 64'(bus.o_out_valid), 64'(mv));
            chk("data", bus.o_out_data, md);
            chk("last", 64'(bus.o_last), 64'(ml));
            chk("res_ready", 64'(bus.o_res_ready), 64'(mready));
            chk("frame_done", 64'(bus.o_frame_done), 64'(done_exp));
            hs       = mv && bus.i_out_ready;
            done_exp = hs && ml;
            if (hs) void'(exp_q.pop_front());
            if (bus.i_res_valid && mready) begin
                tmp = bus.i_res_data;
                for (int k = NW - 1; k >= 0; k--) begin
                    words[k] = tmp[DATA_W-1:0];
                    tmp = tmp >> DATA_W;
                end
                for (int k = 0; k < NW; k++) exp_q.push_back(words[k]);
                acc_cnt++;
            end
        end
    end

    // Downstream ready: always on, 1-0-0 pattern, or random.
    initial begin : ready_drv
        int pc;
        pc = 0;
        bus.i_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus.i_out_ready = (pc % 3 == 0);
                2:       bus.i_out_ready = 1'($urandom_range(0, 1));
                default: bus.i_out_ready = 1'b1;
            endcase
            pc++;
        end
    end

    task automatic send(input logic [RES_W-1:0] data);
        int start;
        bit ok;
        start = acc_cnt;
        ok = 1'b0;
        bus.i_res_valid = 1'b1;
        bus.i_res_data  = data;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(posedge clk);
            #1;
            if (acc_cnt != start) ok = 1'b1;
        end
        if (!ok) timeout_fail("accept");
        bus.i_res_valid = 1'b0;
    endtask

    task automatic wait_q_le(input int n);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (exp_q.size() <= n) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!ok) timeout_fail("drain");
    endtask

    initial begin : stim
        logic [RES_W-1:0] a, b;
        bus.i_res_valid = 1'b0;
        bus.i_res_data  = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(bus.o_out_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.o_res_ready), 64'd1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Directed single frame with the golden first/last words.
        a = rnd512();
        a[511:448] = 64'h47f6a5d15e1a0949;
        a[63:0]    = 64'h1c84c68aa2f54468;
        send(a);
        wait_q_le(0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure 1,0,0 pattern.
        ready_mode = 1;
        send(rnd512());
        wait_q_le(0);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back: second result held while busy, captured on the last-word handshake.
        ready_mode = 0;
        send(rnd512());
        b = rnd512();
        b[511:448] = 64'h7a3afed80c2ab247;
        b[31:0]    = 32'h85f29f8c;
        send(b);
        wait_q_le(0);
        repeat (2) @(posedge clk);
        #1;

        // Busy protection: a different result offered at cnt=3 under random backpressure.
        ready_mode = 2;
        send(rnd512());
        wait_q_le(NW - 3);
        send(rnd512());
        wait_q_le(0);
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame at cnt=4.
        ready_mode = 0;
        send(rnd512());
        wait_q_le(NW - 4);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(bus.o_out_valid), 64'd0);
        chk("midrst_data", bus.o_out_data, 64'd0);
        chk("midrst_ready", 64'(bus.o_res_ready), 64'd1);
        chk("midrst_last", 64'(bus.o_last), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(rnd512());
        wait_q_le(0);
        repeat (2) @(posedge clk);
        #1;

        // Random frames with random gaps and random backpressure.
        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            send(rnd512());
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_q_le(0);
        repeat (3) @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
